// File: rtl/flash_erase_seq_if.sv
// Command/status and flash-datapath signals of the flash erase sequencer.
// Handshake: flash_req_o stays high with stable flash_addr_o/flash_op_o until the datapath answers
// with flash_done_i or flash_error_i in a cycle where flash_req_o is high; responses at other times are ignored.
interface flash_erase_seq_if #(
   parameter int AddrW = 10
);
   logic             start_i;
   logic             bank_i;
   logic [AddrW-1:0] addr_i;
   logic [7:0]       num_pages_i;
   logic             abort_i;
   logic             busy_o;
   logic             done_o;
   logic [1:0]       err_o;
   logic             aborted_o;
   logic [AddrW-1:0] fail_addr_o;
   logic             flash_req_o;
   logic [AddrW-1:0] flash_addr_o;
   logic             flash_op_o;
   logic             flash_done_i;
   logic             flash_error_i;

   modport slave (
      input  start_i, bank_i, addr_i, num_pages_i, abort_i, flash_done_i, flash_error_i,
      output busy_o, done_o, err_o, aborted_o, fail_addr_o, flash_req_o, flash_addr_o, flash_op_o
   );

   modport master (
      output start_i, bank_i, addr_i, num_pages_i, abort_i, flash_done_i, flash_error_i,
      input  busy_o, done_o, err_o, aborted_o, fail_addr_o, flash_req_o, flash_addr_o, flash_op_o
   );
endinterface

// File: rtl/flash_erase_seq.sv
// Sequences page-range or whole-bank erase requests to the flash erase datapath,
// with range checking, per-operation timeout, abort after the in-flight page and error reporting.
module flash_erase_seq #(
   parameter int AddrW         = 10,
   parameter int WordsPerPage  = 4,
   parameter int PagesPerBank  = 128,
   parameter int TimeoutCycles = 1023
) (
   input  logic             clk_i,
   input  logic             rst_i,
   flash_erase_seq_if.slave bus,
   output logic [1:0]       dbg_state_o
);
   localparam int WordsBitWidth = $clog2(WordsPerPage);
   localparam int PagesBitWidth = $clog2(PagesPerBank);
   localparam int TimerW        = $clog2(TimeoutCycles + 1);
   localparam int PageW         = AddrW - WordsBitWidth;
   localparam int SumW          = ((PageW > 8) ? PageW : 8) + 1;

   localparam logic [AddrW-1:0]  PageMask  = ~AddrW'(WordsPerPage - 1);
   localparam logic [AddrW-1:0]  BankMask  = ~AddrW'((1 << (PagesBitWidth + WordsBitWidth)) - 1);
   localparam logic [AddrW-1:0]  PageStep  = AddrW'(WordsPerPage);
   localparam logic [SumW-1:0]   LastPage  = SumW'(2 * PagesPerBank - 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;
   typedef enum logic [1:0] {ERR_OK, ERR_RANGE, ERR_FLASH, ERR_TIMEOUT} err_t;

   state_t            state_q, state_d;
   logic              op_q, op_d;
   logic [AddrW-1:0]  addr_q, addr_d;
   logic [8:0]        remaining_q, remaining_d;
   logic [TimerW-1:0] tmo_q, tmo_d;
   logic              abort_q, abort_d;
   err_t              err_q, err_d;
   logic              aborted_q, aborted_d;
   logic [AddrW-1:0]  fail_q, fail_d;
   logic              abort_now;
   logic [SumW-1:0]   range_end;

   assign range_end = SumW'(bus.addr_i[AddrW-1:WordsBitWidth]) + SumW'(bus.num_pages_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         op_q        <= 1'b0;
         addr_q      <= '0;
         remaining_q <= '0;
         tmo_q       <= '0;
         abort_q     <= 1'b0;
         err_q       <= ERR_OK;
         aborted_q   <= 1'b0;
         fail_q      <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         tmo_q       <= tmo_d;
         abort_q     <= abort_d;
         err_q       <= err_d;
         aborted_q   <= aborted_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      tmo_d       = tmo_q;
      abort_d     = abort_q;
      err_d       = err_q;
      aborted_d   = aborted_q;
      fail_d      = fail_q;
      abort_now   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               err_d     = ERR_OK;
               aborted_d = 1'b0;
               fail_d    = '0;
               abort_d   = 1'b0;
               tmo_d     = '0;
               op_d      = bus.bank_i;
               if (bus.bank_i) begin
                  addr_d      = bus.addr_i & BankMask;
                  remaining_d = 9'd1;
                  state_d     = ISSUE;
               end else if (range_end > LastPage) begin
                  err_d   = ERR_RANGE;
                  fail_d  = bus.addr_i & PageMask;
                  state_d = FIN;
               end else begin
                  addr_d      = bus.addr_i & PageMask;
                  remaining_d = {1'b0, bus.num_pages_i} + 9'd1;
                  state_d     = ISSUE;
               end
            end
         end
         ISSUE: begin
            // An abort seen in this very cycle counts as pending for the completion decision.
            abort_now = abort_q | bus.abort_i;
            abort_d   = abort_now;
            tmo_d     = tmo_q + 1'b1;
            if (bus.flash_error_i) begin
               err_d     = ERR_FLASH;
               fail_d    = addr_q;
               aborted_d = abort_now;
               state_d   = FIN;
            end else if (bus.flash_done_i) begin
               if (remaining_q > 9'd1 && !abort_now) begin
                  remaining_d = remaining_q - 9'd1;
                  addr_d      = addr_q + PageStep;
                  state_d     = GAP;
               end else begin
                  aborted_d = abort_now;
                  state_d   = FIN;
               end
            end else if (tmo_q == TimerLast) begin
               // Counter reaches TimeoutCycles on this, the last permitted ISSUE cycle.
               err_d     = ERR_TIMEOUT;
               fail_d    = addr_q;
               aborted_d = abort_now;
               state_d   = FIN;
            end
         end
         GAP: begin
            if (abort_q || bus.abort_i) begin
               abort_d   = 1'b1;
               aborted_d = 1'b1;
               state_d   = FIN;
            end else begin
               tmo_d   = '0;
               state_d = ISSUE;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o       = (state_q != IDLE);
   assign bus.done_o       = (state_q == FIN);
   assign bus.flash_req_o  = (state_q == ISSUE);
   assign bus.flash_addr_o = addr_q;
   assign bus.flash_op_o   = op_q;
   assign bus.err_o        = err_q;
   assign bus.aborted_o    = aborted_q;
   assign bus.fail_addr_o  = fail_q;
   assign dbg_state_o      = state_q;
endmodule

// File: doc/flash_erase_seq.md
FLASH_ERASE_SEQ -- requirements
Module: flash_erase_seq

Interface
REQ-001 Parameter AddrW, default 10: flash word-address width.
REQ-002 Parameter WordsPerPage, default 4: words per page; WordsBitWidth = $clog2(WordsPerPage).
REQ-003 Parameter PagesPerBank, default 128: pages per bank; PagesBitWidth = $clog2(PagesPerBank).
REQ-004 Parameter TimeoutCycles, default 1023: maximum cycles an issued operation waits for completion; counter width is $clog2(TimeoutCycles+1).
REQ-005 Port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1: synchronous active-high reset.
REQ-007 Port start_i, input, 1: start request; sampled only in IDLE.
REQ-008 Port bank_i, input, 1: 1 = single bank erase, 0 = page-range erase.
REQ-009 Port addr_i, input, AddrW: start word address; low WordsBitWidth bits are ignored.
REQ-010 Port num_pages_i, input, 8: page count minus one (0 = 1 page, 255 = 256 pages); ignored when bank_i=1.
REQ-011 Port abort_i, input, 1: stop after the in-flight page.
REQ-012 Port busy_o, output, 1: high in every state except IDLE.
REQ-013 Port done_o, output, 1: one-cycle completion pulse.
REQ-014 Port err_o, output, 2: status, valid from done_o until the next start: 0 ok, 1 range, 2 flash error, 3 timeout.
REQ-015 Port aborted_o, output, 1: sequence ended by abort_i; valid with err_o.
REQ-016 Port fail_addr_o, output, AddrW: page-aligned address of the failing operation; 0 when err_o=0.
REQ-017 Port flash_req_o, output, 1: operation request to the flash erase datapath.
REQ-018 Port flash_addr_o, output, AddrW: address presented with flash_req_o.
REQ-019 Port flash_op_o, output, 1: 0 = PageErase, 1 = BankErase.
REQ-020 Ports flash_done_i and flash_error_i, input, 1 each: completion and failure of the current request.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, GAP and FIN.
REQ-022 IDLE with start_i=1 SHALL latch the command. Range check: if bank_i=0 and page(addr_i) + num_pages_i > 2*PagesPerBank-1, go to FIN with err_o=1 and fail_addr_o = page-aligned addr_i, issuing no request. Otherwise go to ISSUE.
REQ-023 In page mode, flash_addr_o SHALL be the current page index << WordsBitWidth with flash_op_o=0; in bank mode, addr_i with its low PagesBitWidth+WordsBitWidth bits cleared and flash_op_o=1.
REQ-024 flash_req_o SHALL be high exactly while in ISSUE; flash_addr_o and flash_op_o SHALL stay stable throughout ISSUE.
REQ-025 In ISSUE, flash_error_i=1 SHALL go to FIN with err_o=2 and fail_addr_o=flash_addr_o; flash_error_i has priority over a simultaneous flash_done_i.
REQ-026 In ISSUE, flash_done_i=1 with pages remaining and no pending abort SHALL go to GAP and increment the page index by one. Otherwise it SHALL go to FIN.
REQ-027 GAP SHALL last exactly one cycle with flash_req_o=0, then return to ISSUE.
REQ-028 A timeout counter SHALL clear on entry to ISSUE and increment each ISSUE cycle. When it reaches TimeoutCycles without done or error, go to FIN with err_o=3 and fail_addr_o=flash_addr_o; flash_done_i or flash_error_i in that same cycle takes priority over timeout.
REQ-029 abort_i=1 in any ISSUE or GAP cycle SHALL set a sticky abort flag.
- ISSUE: the current operation completes, then the FSM goes to FIN with aborted_o=1.
- GAP: goes directly to FIN with aborted_o=1.
- err_o reflects any error from the final operation.
REQ-030 FIN SHALL last one cycle with done_o=1, then return to IDLE.
REQ-031 start_i and abort_i outside their sampling states SHALL be ignored; abort_i in IDLE has no effect.
REQ-032 The remaining-page counter SHALL be 9 bits so that 256 pages issue exactly 256 requests.

Reset
REQ-033 rst_i=1 SHALL force IDLE and clear all state on the next edge, including mid-sequence. Reset values: flash_req_o=0, busy_o=0, done_o=0, err_o=0, aborted_o=0, fail_addr_o=0, flash_addr_o=0, flash_op_o=0.
REQ-034 Reset mid-ISSUE SHALL drop flash_req_o the cycle after rst_i is sampled; no done_o pulse results.

Verification
REQ-035 Page range: addr_i=0x010, num_pages_i=2, flash_done_i 3 cycles after each req -> requests at 0x010, 0x014, 0x018, each separated by one low cycle; done_o with err_o=0.
REQ-036 Bank: bank_i=1, addr_i=0x2A7 -> single request flash_op_o=1 at flash_addr_o=0x200; done_o with err_o=0.
REQ-037 Range error: addr_i=0x3F8 (page 254), num_pages_i=2 -> no flash_req_o; done_o 1 cycle after start with err_o=1 and fail_addr_o=0x3F8.
REQ-038 Flash error: flash_error_i and flash_done_i both asserted on the second page of a 4-page sequence -> err_o=2, fail_addr_o equals the second page address, no third request.
REQ-039 Timeout and abort:
- No response for TimeoutCycles -> err_o=3.
- Separate run: abort_i during GAP of a 10-page sequence -> aborted_o=1 and err_o=0 after the first page only.
REQ-040 Reset: rst_i asserted mid-ISSUE -> flash_req_o=0 and busy_o=0 next cycle; a new start_i then works normally.
